// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: fetch FSM states, NOP encoding and default reset PC shared by the fetch unit files
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory req/gnt/rvalid bus; master = fetch unit (req, addr out), slave = memory (gnt, rvalid, rdata out)
interface instr_fetch_unit_if #(parameter int Width = 32);
  logic imem_req;
  logic [Width-1:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [Width-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry instruction+PC buffer; load captures din_*, clear empties it (clear wins), valid flags contents
module fetch_hold_buf
  import instr_fetch_unit_pkg::*;
#(parameter int Width = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [Width-1:0] din_instr,
  input  logic [Width-1:0] din_pc,
  output logic             valid,
  output logic [Width-1:0] instr,
  output logic [Width-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= Width'(NOP);
      pc <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= din_instr;
      pc <= din_pc;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding IF stage; clk/rst_n, mem bus (master), PCen/IFIDen stalls, redirect/target, IF/ID outputs PC1/Instruction/if_valid
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int Width = 32,
  parameter logic [Width-1:0] ResetPC = Width'(RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master mem,
  input  logic               PCen,
  input  logic               IFIDen,
  input  logic               redirect,
  input  logic [Width-1:0]   target,
  output logic [Width-1:0]   PC1,
  output logic [Width-1:0]   Instruction,
  output logic               if_valid
);
  state_t state, nxt;
  logic drop, drop_nxt, req, go, take, dlv_hb, dlv, hb_valid;
  logic [Width-1:0] fetch_pc, hb_instr, hb_pc;
  assign mem.imem_req = req;
  assign mem.imem_addr = fetch_pc;
  assign go = PCen & IFIDen;
  // a response is usable only when nothing has invalidated it
  assign take = state == S_WAIT && mem.imem_rvalid && !redirect && !drop;
  assign dlv_hb = state == S_HOLD && hb_valid && go && !redirect;
  assign dlv = (take && go) || dlv_hb;
  always_comb begin
    nxt = state == S_REQ ? (req && mem.imem_gnt ? S_WAIT : S_REQ)
        : state == S_WAIT ? (!mem.imem_rvalid ? S_WAIT : (redirect || drop || go) ? S_REQ : S_HOLD)
        : (redirect || go) ? S_REQ : S_HOLD;
    // a response arriving together with a redirect is consumed here, so no drop is owed
    drop_nxt = state == S_WAIT && mem.imem_rvalid ? 1'b0
             : redirect && (state == S_WAIT || (state == S_REQ && req && mem.imem_gnt)) ? 1'b1
             : drop;
  end
  fetch_hold_buf #(.Width(Width)) u_hold (
    .clk(clk),
    .rst_n(rst_n),
    .load(take && !go),
    .clear(state == S_HOLD && (redirect || go)),
    .din_instr(mem.imem_rdata),
    .din_pc(fetch_pc),
    .valid(hb_valid),
    .instr(hb_instr),
    .pc(hb_pc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_REQ;
      drop <= 1'b0;
      req <= 1'b0;
      fetch_pc <= ResetPC;
      PC1 <= '0;
      Instruction <= Width'(NOP);
      if_valid <= 1'b0;
    end else begin
      state <= nxt;
      drop <= drop_nxt;
      req <= nxt == S_REQ;
      fetch_pc <= redirect ? target & ~Width'(3) : dlv ? fetch_pc + Width'(4) : fetch_pc;
      if (redirect || (IFIDen && !dlv)) begin
        Instruction <= Width'(NOP);
        if_valid <= 1'b0;
      end else if (dlv) begin
        Instruction <= dlv_hb ? hb_instr : mem.imem_rdata;
        PC1 <= dlv_hb ? hb_pc : fetch_pc;
        if_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus random fetch traffic checked against a request-level reference model
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pcen, ifiden, redir;
  logic [31:0] tgt, pc1, instr;
  logic ifv;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.Width(32)) bus ();
  instr_fetch_unit #(.Width(32), .ResetPC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem(bus),
    .PCen(pcen),
    .IFIDen(ifiden),
    .redirect(redir),
    .target(tgt),
    .PC1(pc1),
    .Instruction(instr),
    .if_valid(ifv)
  );
  int vectors = 0;
  int miscompares = 0;
  logic m_req, m_out, m_drop, m_held, m_valid;
  logic [31:0] m_fpc, m_hw, m_hpc, m_instr, m_pc1;
  logic mem_busy, force_rv;
  int mem_cnt, lat;
  logic [31:0] mem_data;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'd8 ? 32'h0050_0093 : (a ^ 32'h5A00_0000) | 32'h13;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_fpc = 32'h0; m_req = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0;
    m_hw = '0; m_hpc = '0; m_instr = NOP; m_pc1 = '0; m_valid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_data = '0;
  endtask
  // one clock: memory answers, model predicts, DUT is compared just after the edge
  task automatic cyc();
    logic rv, go, acc, dl;
    logic [31:0] dw, dp;
    rv = force_rv || (mem_busy && mem_cnt == 1);
    bus.imem_rvalid = rv;
    bus.imem_rdata = (mem_busy && mem_cnt == 1) ? mem_data : $urandom;
    go = pcen & ifiden;
    acc = m_req & bus.imem_gnt;
    dl = 1'b0; dw = '0; dp = '0;
    if (mem_busy && mem_cnt == 1) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin mem_busy = 1'b1; mem_cnt = lat; mem_data = memf(m_fpc); end
    if (m_held && !redir && go) begin dl = 1'b1; dw = m_hw; dp = m_hpc; end
    if (m_held && (redir || go)) m_held = 1'b0;
    if (m_out && rv) begin
      if (!redir && !m_drop) begin
        if (go) begin dl = 1'b1; dw = bus.imem_rdata; dp = m_fpc; end
        else begin m_held = 1'b1; m_hw = bus.imem_rdata; m_hpc = m_fpc; end
      end
      m_out = 1'b0;
      m_drop = 1'b0;
    end else if (m_out && redir) m_drop = 1'b1;
    if (acc) begin m_out = 1'b1; m_drop = redir; end
    if (redir || (ifiden && !dl)) begin m_instr = NOP; m_valid = 1'b0; end
    else if (dl) begin m_instr = dw; m_pc1 = dp; m_valid = 1'b1; end
    m_fpc = redir ? {tgt[31:2], 2'b00} : dl ? m_fpc + 32'd4 : m_fpc;
    m_req = !m_out && !m_held;
    @(posedge clk);
    #1;
    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    chk("imem_addr", bus.imem_addr, m_fpc);
    chk("Instruction", instr, m_instr);
    chk("PC1", pc1, m_pc1);
    chk("if_valid", 32'(ifv), 32'(m_valid));
    @(negedge clk);
  endtask
  initial begin
    pcen = 1'b1; ifiden = 1'b1; redir = 1'b0; tgt = '0; force_rv = 1'b0; lat = 1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc1", pc1, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", 32'(ifv), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_gnt = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 3) begin chk("seq_pc0", pc1, 32'h0); chk("seq_v0", 32'(ifv), 32'h1); end
      if (i == 4) chk("seq_bubble", instr, NOP);
      if (i == 5) begin chk("seq_pc4", pc1, 32'h4); chk("seq_v4", 32'(ifv), 32'h1); end
      if (i == 6) chk("seq_v6", 32'(ifv), 32'h0);
    end
    pcen = 1'b0; ifiden = 1'b0;
    repeat (3) begin
      cyc();
      chk("hold_noreq", 32'(bus.imem_req), 32'h0);
      chk("hold_pc1", pc1, 32'h4);
    end
    pcen = 1'b1; ifiden = 1'b1;
    cyc();
    chk("release_instr", instr, 32'h0050_0093);
    chk("release_pc1", pc1, 32'h8);
    lat = 2;
    cyc();
    bus.imem_gnt = 1'b0; redir = 1'b1; tgt = 32'h103;
    cyc();
    chk("redir_bubble_v", 32'(ifv), 32'h0);
    chk("redir_bubble_i", instr, NOP);
    redir = 1'b0;
    cyc();
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_req", 32'(bus.imem_req), 32'h1);
    chk("redir_dropped", 32'(ifv), 32'h0);
    cyc();
    chk("nognt_addr1", bus.imem_addr, 32'h100);
    redir = 1'b1; tgt = 32'h200;
    cyc();
    redir = 1'b0;
    chk("nognt_redir_addr", bus.imem_addr, 32'h200);
    repeat (2) begin
      cyc();
      chk("nognt_addr", bus.imem_addr, 32'h200);
      chk("nognt_req", 32'(bus.imem_req), 32'h1);
    end
    bus.imem_gnt = 1'b1; lat = 3;
    cyc();
    bus.imem_gnt = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_pc1", pc1, 32'h0);
    chk("arst_instr", instr, NOP);
    chk("arst_valid", 32'(ifv), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    force_rv = 1'b1;
    cyc();
    force_rv = 1'b0;
    chk("stale_ignored", 32'(ifv), 32'h0);
    chk("post_rst_req", 32'(bus.imem_req), 32'h1);
    redir = 1'b1; tgt = 32'hFFFF_FFFF;
    cyc();
    redir = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_gnt = 1'b1; lat = 1;
    cyc();
    bus.imem_gnt = 1'b0;
    cyc();
    chk("wrap_pc1", pc1, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(ifv), 32'h1);
    chk("wrap_next", bus.imem_addr, 32'h0);
    for (int i = 0; i < 400; i++) begin
      pcen = $urandom_range(0, 3) != 0;
      ifiden = $urandom_range(0, 3) != 0;
      redir = $urandom_range(0, 9) == 0;
      tgt = $urandom;
      bus.imem_gnt = $urandom_range(0, 1) == 1;
      lat = $urandom_range(1, 3);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter Width, default 32: datapath, PC and instruction width.
REQ-002 Parameter ResetPC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 PCen  input  1  hazard-unit PC advance enable; 0 = stall fetch PC.
REQ-006 IFIDen  input  1  hazard-unit IF/ID register enable; 0 = hold IF/ID.
REQ-007 redirect  input  1  taken branch/jump from a later stage; flush and refetch.
REQ-008 target  input  Width  redirect address; bits [1:0] ignored, treated as 0.
REQ-009 imem_req  output  1  instruction-memory request valid.
REQ-010 imem_addr  output  Width  request address, word aligned.
REQ-011 imem_gnt  input  1  request accepted this cycle.
REQ-012 imem_rvalid  input  1  read data valid; at most one per granted request, 1+ cycles after gnt.
REQ-013 imem_rdata  input  Width  fetched instruction.
REQ-014 PC1  output  Width  PC of the instruction held in IF/ID, consumed by decode.
REQ-015 Instruction  output  Width  IF/ID instruction word.
REQ-016 if_valid  output  1  IF/ID holds a real instruction; 0 = bubble.

Function
REQ-017 FSM states REQ, WAIT, HOLD; only one memory request outstanding at any time.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; imem_addr stable while req=1 and gnt=0; gnt moves the FSM to WAIT.
REQ-019 WAIT: imem_req=0; rvalid with PCen=1 and IFIDen=1 delivers: Instruction<=rdata, PC1<=fetch_pc, if_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^Width), go to REQ.
REQ-020 WAIT: rvalid with PCen=0 or IFIDen=0 stores rdata and its PC in a one-entry hold buffer and goes to HOLD; IF/ID is unchanged.
REQ-021 HOLD: imem_req=0; the first cycle with PCen=1 and IFIDen=1 delivers the buffer contents as in REQ-019 and goes to REQ.
REQ-022 With IFIDen=1 and no delivery in a cycle, IF/ID loads a bubble: Instruction=NOP 32'h0000_0013, if_valid=0, PC1 unchanged.
REQ-023 With IFIDen=0, Instruction, PC1 and if_valid hold their values, except under redirect.
REQ-024 Redirect has top priority over stall and delivery: fetch_pc<=target&~3, and IF/ID loads a bubble whatever the value of IFIDen.
REQ-025 Redirect in REQ without gnt: the next cycle presents target on imem_addr with req=1.
REQ-026 Redirect in REQ with gnt in the same cycle, or in WAIT: set the drop flag and stay in or enter WAIT.
REQ-027 Redirect in HOLD: discard the hold buffer and go to REQ.
REQ-028 Drop flag: the next rvalid is discarded with no IF/ID update; the flag clears and the FSM goes to REQ with the redirected fetch_pc.
REQ-029 Redirect coinciding with rvalid in WAIT: the returning word is discarded, the drop flag is not set, and the FSM goes to REQ at the target.
REQ-030 Peak throughput is one instruction per 2 cycles (gnt in cycle N, rvalid in N+1, next req in N+2).

Reset
REQ-031 Reset to the values in REQ-032 is asynchronous on rst_n low; release is sampled synchronously on clk.
REQ-032 Reset values: state=REQ, fetch_pc=ResetPC, imem_req=0 while rst_n=0, imem_addr=ResetPC, PC1=0, Instruction=NOP, if_valid=0, drop flag=0, hold buffer empty.
REQ-033 imem_req asserts on the first clk edge after rst_n deasserts; a reset during WAIT abandons the outstanding response, and the memory side is reset with the block.

Structure
REQ-034 A shared package holds the FSM state enum (REQ/WAIT/HOLD), the NOP constant 32'h0000_0013, and the default ResetPC.
REQ-035 The one-entry hold buffer is one sub-module, fetch_hold_buf, with load, clear and valid ports; the rest of the block is flat.

Verification
REQ-036 Reset then gnt=1 always, rvalid 1 cycle after gnt, stalls off -> PC1 sequence 0,4,8 with if_valid=1 every 2nd cycle and NOP bubbles between.
REQ-037 IFIDen=PCen=0 for 3 cycles while rvalid returns 0x00500093 at PC 8 -> HOLD, IF/ID unchanged; stall release -> Instruction=0x00500093, PC1=8 in the next cycle, and no new req during HOLD.
REQ-038 Redirect with target=0x103 while in WAIT -> next rvalid dropped, next imem_addr=0x100, and IF/ID bubble in the redirect cycle.
REQ-039 gnt held low for 4 cycles -> imem_addr stays constant and req stays high; a redirect in cycle 2 changes imem_addr to the target on the next cycle.
REQ-040 rst_n asserted low mid-WAIT -> all outputs take their reset values without waiting for a clock edge, and the stale rvalid after release is ignored; fetch_pc=0xFFFFFFFC wraps to 0 after delivery.
